nonce_scheduler: RTL and testbench
==================================

# nonce_scheduler

Schedules the per-nonce hashing work of `bitcoin_hash` across `NUM_CORES` parallel SHA-256 second/third-phase engines. It hands out nonces 0..`NUM_NONCES`-1 to free cores with a start/done handshake and collects each core's final H0 word. It also writes the results to memory in nonce order through the single memory write port. It sits between the top-level bitcoin FSM, which runs phase 1 and then pulses `start`, and the hash cores plus the memory port.

## Interface
- `NUM_NONCES`, 16: nonces to hash; ≥1, ≤256.
- `NUM_CORES`, 4: parallel hash cores; ≥1, ≤`NUM_NONCES`.
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse; begins a run (sampled only in IDLE).
- `output_addr`  in  16  word address of result for nonce 0; sampled with `start`.
- `busy`  out  1  high from the cycle after accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse after the last result write.
- `core_start`  out  NUM_CORES  per-core one-cycle launch pulse.
- `core_nonce`  out  NUM_CORES×32  per-core nonce; stable from `core_start` until that core's `core_done`.
- `core_done`  in  NUM_CORES  per-core one-cycle completion pulse.
- `core_hash`  in  NUM_CORES×32  per-core final H0; valid in the `core_done` cycle.
- `mem_we`  out  1  write strobe.
- `mem_addr`  out  16  write address.
- `mem_write_data`  out  32  write data.

## Operation
- FSM states: IDLE, RUN, FINISH.
- IDLE → RUN on `start`. The transition latches `output_addr` and clears `next_nonce`, `wr_ptr`, result-valid bits and core-busy bits. `start` in RUN or FINISH is ignored.
- RUN, dispatch:
  - At most one dispatch per cycle.
  - If `next_nonce` < `NUM_NONCES` and some core is not busy, the lowest-index free core gets `core_start`=1 and `core_nonce`=`next_nonce`.
  - That core is marked busy and `next_nonce` increments.
- RUN, collection:
  - Every core with `core_done`=1 and busy=1 is handled in the same cycle, any number simultaneously.
  - Its `core_hash` is stored into `hout[core_nonce]`, the valid bit is set and busy is cleared.
  - A core freed this way is dispatchable from the next cycle, not the same cycle.
  - `core_done` from a non-busy core is ignored: no store, no state change.
- RUN, write-back:
  - If the valid bit of `hout[wr_ptr]` is set, assert `mem_we`=1 with `mem_addr`=latched `output_addr`+`wr_ptr` (16-bit wrap) and `mem_write_data`=`hout[wr_ptr]`.
  - Then increment `wr_ptr`.
  - Writes are strictly in nonce order, one per cycle, so out-of-order completions wait in the buffer.
- RUN → FINISH in the cycle `wr_ptr` reaches `NUM_NONCES`.
- FINISH: `done`=1 for one cycle, then → IDLE.
- Reset, including mid-run:
  - Next cycle is IDLE; all busy and valid bits are clear.
  - In-flight core results that arrive after reset are ignored by the non-busy rule.
- Reset values: `busy`=0, `done`=0, `core_start`=0, `core_nonce`=0, `mem_we`=0, `mem_addr`=0, `mem_write_data`=0.
- Widths: counters are $clog2(`NUM_NONCES`+1) bits. `core_nonce` is zero-extended to 32.

## Timing
- `start` sampled at edge E0. Core 0 gets `core_start` in cycle 1 with nonce 0. Core k gets nonce k in cycle k+1 while cores remain free.
- `core_done` captured at edge Ed. Write of that nonce can occur in cycle Ed+1 at the earliest, when it is at `wr_ptr`.
- The last write occurs in cycle W, with `mem_we` high. `done` is high in cycle W+1. `busy` falls after W+1, and a new `start` is accepted at edge W+2.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `bitcoin_pkg` holds the state enum (`sched_state_t`), `NONCE_W`=32, `ADDR_W`=16 and `WORD_W`=32. `bitcoin_hash` shares the same package.
- One sub-module: `lowest_free_pick`. It is parameterized by `NUM_CORES` and is a combinational priority encoder from the busy vector to {found, index}.
- Result buffer `hout[NUM_NONCES]` and the valid bits stay inside `nonce_scheduler`.

## Test plan
- Defaults; each core asserts `core_done` 20 cycles after its `core_start` with `core_hash`=0xA000_0000+nonce; `output_addr`=0x0100.
  - Required: 16 writes to 0x0100..0x010F with data 0xA000_0000..0xA000_000F in order.
  - Required: `done` pulses once, the cycle after the last write.
- Out-of-order completion: core latencies are 40, 10, 25 and 5 cycles for cores 0..3.
  - Required: no write occurs until nonce 0 completes, then writes are strictly ascending.
  - Required: all 16 words are correct.
- Simultaneous done: all 4 cores pulse `core_done` in the same cycle.
  - Required: all four results are stored.
  - Required: the four freed cores are re-dispatched in cycles +1..+4, lowest index first.
- Reset mid-run after 6 dispatches.
  - Required: one cycle later `busy`=0 and `core_start`=0; stale `core_done` pulses cause no `mem_we`.
  - Required: a fresh `start` then yields exactly 16 correct writes.
- Spurious and ignored inputs.
  - `core_done` pulsed on an idle core: no write, no state change.
  - `start` pulsed during RUN: run is unaffected, still exactly one `done`.
  - `output_addr`=0xFFF8: addresses wrap from 0xFFF8..0xFFFF to 0x0000..0x0007.
- Edge case `NUM_NONCES`=1, `NUM_CORES`=1: one dispatch and one write, then `done`; `busy` spans exactly start+1 through `done`.

Source files
------------

// File: rtl/bitcoin_pkg.sv
// Shared types and widths for the bitcoin_hash datapath and its nonce scheduler.
package bitcoin_pkg;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} sched_state_t;
   localparam int NONCE_W = 32;
   localparam int ADDR_W  = 16;
   localparam int WORD_W  = 32;
endpackage

// File: rtl/nonce_scheduler_if.sv
// Control, per-core start/done and memory write signals of the nonce scheduler.
interface nonce_scheduler_if
   import bitcoin_pkg::*;
#(parameter int NUM_CORES = 4) ();
   logic                                start;
   logic [ADDR_W-1:0]                   output_addr;
   logic                                busy;
   logic                                done;
   logic [NUM_CORES-1:0]                core_start;
   logic [NUM_CORES-1:0][NONCE_W-1:0]   core_nonce;
   logic [NUM_CORES-1:0]                core_done;
   logic [NUM_CORES-1:0][WORD_W-1:0]    core_hash;
   logic                                mem_we;
   logic [ADDR_W-1:0]                   mem_addr;
   logic [WORD_W-1:0]                   mem_write_data;

   modport master (
      input  start, output_addr, core_done, core_hash,
      output busy, done, core_start, core_nonce, mem_we, mem_addr, mem_write_data
   );
   modport slave (
      output start, output_addr, core_done, core_hash,
      input  busy, done, core_start, core_nonce, mem_we, mem_addr, mem_write_data
   );
endinterface

// File: rtl/nonce_scheduler_lowest_free_pick.sv
// Priority encoder: index of the lowest-numbered non-busy core.
module lowest_free_pick #(
   parameter  int NUM_CORES = 4,
   localparam int KW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic [NUM_CORES-1:0] busy,
   output logic                 found,
   output logic [KW-1:0]        idx
);
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            found = 1'b1;
            idx   = KW'(i);
         end
      end
   end
endmodule

// File: rtl/nonce_scheduler.sv
// Dispatches nonces to free hash cores, buffers their H0 results and writes
// them back to memory strictly in nonce order.
module nonce_scheduler
   import bitcoin_pkg::*;
#(
   parameter int NUM_NONCES = 16,
   parameter int NUM_CORES  = 4
) (
   input logic               clk,
   input logic               reset,
   nonce_scheduler_if.master bus
);
   localparam int CW = $clog2(NUM_NONCES + 1);
   localparam int IW = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
   localparam int KW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_NONCES);

   sched_state_t                  state_q, state_d;
   logic [CW-1:0]                 next_nonce_q, next_nonce_d;
   logic [CW-1:0]                 wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]             base_q, base_d;
   logic [NUM_CORES-1:0]          cbusy_q, cbusy_d;
   logic [NUM_CORES-1:0][CW-1:0]  cnonce_q, cnonce_d;
   logic [NUM_NONCES-1:0]         valid_q, valid_d;
   logic [WORD_W-1:0]             hout_q [NUM_NONCES];
   logic [WORD_W-1:0]             hout_d [NUM_NONCES];
   logic                          busy_q, busy_d, done_q, done_d;
   logic [NUM_CORES-1:0]          core_start_q, core_start_d;
   logic                          mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]             mem_addr_q, mem_addr_d;
   logic [WORD_W-1:0]             mem_data_q, mem_data_d;
   logic                          disp_en, pick_found;
   logic [KW-1:0]                 pick_idx;
   logic [NUM_CORES-1:0]          pick_busy;

   // On the start edge every core counts as free, so nonce 0 goes out immediately.
   assign pick_busy = (state_q == S_IDLE) ? '0 : cbusy_q;

   lowest_free_pick #(.NUM_CORES(NUM_CORES)) u_pick (
      .busy  (pick_busy),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d      = state_q;
      next_nonce_d = next_nonce_q;
      wr_ptr_d     = wr_ptr_q;
      base_d       = base_q;
      cbusy_d      = cbusy_q;
      cnonce_d     = cnonce_q;
      valid_d      = valid_q;
      hout_d       = hout_q;
      core_start_d = '0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      disp_en      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d      = S_RUN;
               base_d       = bus.output_addr;
               next_nonce_d = '0;
               wr_ptr_d     = '0;
               valid_d      = '0;
               cbusy_d      = '0;
               disp_en      = 1'b1;
            end
         end
         S_RUN: begin
            for (int c = 0; c < NUM_CORES; c++) begin
               if (bus.core_done[c] && cbusy_q[c]) begin
                  hout_d[cnonce_q[c][IW-1:0]]  = bus.core_hash[c];
                  valid_d[cnonce_q[c][IW-1:0]] = 1'b1;
                  cbusy_d[c]                   = 1'b0;
               end
            end
            // Write-back sees results captured this cycle, so a result at wr_ptr leaves next cycle.
            if (wr_ptr_q == LAST) begin
               state_d = S_FINISH;
            end else if (valid_d[wr_ptr_q[IW-1:0]]) begin
               mem_we_d   = 1'b1;
               mem_addr_d = base_q + ADDR_W'(wr_ptr_q);
               mem_data_d = hout_d[wr_ptr_q[IW-1:0]];
               wr_ptr_d   = wr_ptr_q + CW'(1);
            end
            disp_en = 1'b1;
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (disp_en && pick_found && (next_nonce_d < LAST)) begin
         core_start_d[pick_idx] = 1'b1;
         cnonce_d[pick_idx]     = next_nonce_d;
         cbusy_d[pick_idx]      = 1'b1;
         next_nonce_d           = next_nonce_d + CW'(1);
      end
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_FINISH);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         next_nonce_q <= '0;
         wr_ptr_q     <= '0;
         base_q       <= '0;
         cbusy_q      <= '0;
         cnonce_q     <= '0;
         valid_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         core_start_q <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         next_nonce_q <= next_nonce_d;
         wr_ptr_q     <= wr_ptr_d;
         base_q       <= base_d;
         cbusy_q      <= cbusy_d;
         cnonce_q     <= cnonce_d;
         valid_q      <= valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         core_start_q <= core_start_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
      end
   end

   // Buffer contents are qualified by valid_q, so they need no reset.
   always_ff @(posedge clk) hout_q <= hout_d;

   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.core_start     = core_start_q;
   assign bus.mem_we         = mem_we_q;
   assign bus.mem_addr       = mem_addr_q;
   assign bus.mem_write_data = mem_data_q;

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_nonce
      assign bus.core_nonce[g] = NONCE_W'(cnonce_q[g]);
   end
endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench: behavioural hash cores with per-test latencies and a write/done monitor.
module tb_nonce_scheduler;
   import bitcoin_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   nonce_scheduler_if #(.NUM_CORES(4)) bus ();
   nonce_scheduler_if #(.NUM_CORES(1)) bus1 ();

   nonce_scheduler #(.NUM_NONCES(16), .NUM_CORES(4)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   nonce_scheduler #(.NUM_NONCES(1), .NUM_CORES(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---- 4-core model and monitor ----
   int                 lat_mode = 0;
   int                 rem [4] = '{default: 0};
   logic [31:0]        mnonce [4];
   logic [3:0]         mdl_done = '0, inj_done = '0;
   logic [3:0][31:0]   mdl_hash = '0, inj_hash = '0;
   assign bus.core_done = mdl_done | inj_done;
   assign bus.core_hash = mdl_hash | inj_hash;

   int          st_cyc[$], st_core[$];
   logic [31:0] st_nonce[$];
   logic [15:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          wr_cyc[$];
   int          done_cnt = 0, done_cyc = 0, busy_rise = 0, busy_fall = 0, n0_done_cyc = 0;
   logic        prev_busy = 1'b0;

   function automatic int lat_of(input int c, input logic [31:0] n);
      case (lat_mode)
         1: case (c)
               0: return 40;
               1: return 10;
               2: return 25;
               default: return 5;
            endcase
         2: return (n < 4) ? 23 - c : 20;
         default: return 20;
      endcase
   endfunction

   always @(negedge clk) begin
      mdl_done = '0;
      mdl_hash = '0;
      for (int c = 0; c < 4; c++) begin
         if (bus.core_start[c]) begin
            rem[c]    = lat_of(c, bus.core_nonce[c]);
            mnonce[c] = bus.core_nonce[c];
            st_cyc.push_back(cyc);
            st_core.push_back(c);
            st_nonce.push_back(bus.core_nonce[c]);
         end else if (rem[c] > 0) begin
            rem[c]--;
            if (rem[c] == 0) begin
               mdl_done[c] = 1'b1;
               mdl_hash[c] = 32'hA000_0000 + mnonce[c];
               if (mnonce[c] == 0) n0_done_cyc = cyc;
            end
         end
      end
      if (bus.mem_we) begin
         wr_addr.push_back(bus.mem_addr);
         wr_data.push_back(bus.mem_write_data);
         wr_cyc.push_back(cyc);
      end
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus.busy && !prev_busy) busy_rise = cyc;
      if (!bus.busy && prev_busy) busy_fall = cyc;
      prev_busy = bus.busy;
   end

   // ---- 1-core model and monitor ----
   int          rem1 = 0, st1_cnt = 0, st1_cyc = 0, wr1_cnt = 0, wr1_cyc = 0;
   int          d1_cnt = 0, d1_cyc = 0, b1_rise = 0, b1_fall = 0;
   logic [31:0] n1 = '0, st1_nonce = '0, wr1_data = '0;
   logic [15:0] wr1_addr = '0;
   logic        pb1 = 1'b0;

   always @(negedge clk) begin
      bus1.core_done = '0;
      bus1.core_hash = '0;
      if (bus1.core_start[0]) begin
         rem1 = 20; n1 = bus1.core_nonce[0];
         st1_cnt++; st1_cyc = cyc; st1_nonce = bus1.core_nonce[0];
      end else if (rem1 > 0) begin
         rem1--;
         if (rem1 == 0) begin
            bus1.core_done[0] = 1'b1;
            bus1.core_hash[0] = 32'hA000_0000 + n1;
         end
      end
      if (bus1.mem_we) begin
         wr1_cnt++; wr1_cyc = cyc; wr1_addr = bus1.mem_addr; wr1_data = bus1.mem_write_data;
      end
      if (bus1.done) begin d1_cnt++; d1_cyc = cyc; end
      if (bus1.busy && !pb1) b1_rise = cyc;
      if (!bus1.busy && pb1) b1_fall = cyc;
      pb1 = bus1.busy;
   end

   // ---- run helpers ----
   task automatic do_run(input logic [15:0] addr, input int mode, input int spur_at,
                         output int c0, output int wb, output int sb, output int db);
      lat_mode = mode;
      wb = wr_addr.size(); sb = st_cyc.size(); db = done_cnt;
      @(negedge clk);
      bus.output_addr = addr; bus.start = 1'b1; c0 = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 2000 && done_cnt == db; i++) begin
         @(negedge clk);
         bus.start = (spur_at > 0 && cyc - c0 == spur_at);
      end
      bus.start = 1'b0;
      if (done_cnt == db) chk("run_timeout", 1, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_writes(input string t, input int wb, input int db, input logic [15:0] addr);
      chk({t, "_wr_count"}, wr_addr.size() - wb, 16);
      for (int i = 0; i < 16 && wb + i < wr_addr.size(); i++) begin
         logic [15:0] ea;
         ea = addr + 16'(i);
         chk($sformatf("%s_wr%0d_addr", t, i), wr_addr[wb+i], ea);
         chk($sformatf("%s_wr%0d_data", t, i), wr_data[wb+i], 32'hA000_0000 + i);
      end
      chk({t, "_done_once"}, done_cnt - db, 1);
      if (wr_cyc.size() > wb)
         chk({t, "_done_after_last"}, done_cyc, wr_cyc[wr_cyc.size()-1] + 1);
      chk({t, "_busy_fall"}, busy_fall, done_cyc + 1);
   endtask

   initial begin
      int c0, wb, sb, db, n, c1;
      bus.start = 1'b0; bus.output_addr = '0;
      bus1.start = 1'b0; bus1.output_addr = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_core_start", bus.core_start, 0);
      chk("rst_core_nonce", |bus.core_nonce, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_data", bus.mem_write_data, 0);
      reset = 1'b0;
      @(negedge clk);

      // default latency 20
      do_run(16'h0100, 0, 0, c0, wb, sb, db);
      chk_writes("dflt", wb, db, 16'h0100);
      chk("dflt_busy_rise", busy_rise, c0 + 1);
      for (int k = 0; k < 4 && sb + k < st_cyc.size(); k++) begin
         chk($sformatf("dflt_disp%0d_cyc", k), st_cyc[sb+k], c0 + k + 1);
         chk($sformatf("dflt_disp%0d_core", k), st_core[sb+k], k);
         chk($sformatf("dflt_disp%0d_nonce", k), st_nonce[sb+k], k);
      end

      // out-of-order completion
      do_run(16'h0100, 1, 0, c0, wb, sb, db);
      chk_writes("ooo", wb, db, 16'h0100);
      if (wr_cyc.size() > wb)
         chk("ooo_first_after_n0", wr_cyc[wb] > n0_done_cyc, 1);

      // all four cores complete together in relative cycle 24
      do_run(16'h0100, 2, 0, c0, wb, sb, db);
      chk_writes("simul", wb, db, 16'h0100);
      for (int k = 0; k < 4 && sb + 4 + k < st_cyc.size(); k++) begin
         chk($sformatf("simul_redisp%0d_cyc", k), st_cyc[sb+4+k], c0 + 26 + k);
         chk($sformatf("simul_redisp%0d_core", k), st_core[sb+4+k], k);
         chk($sformatf("simul_redisp%0d_nonce", k), st_nonce[sb+4+k], 4 + k);
      end

      // reset after six dispatches
      lat_mode = 0; sb = st_cyc.size();
      @(negedge clk);
      bus.output_addr = 16'h0100; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (st_cyc.size() - sb < 6 && n < 200) begin @(negedge clk); n++; end
      chk("rst_mid_reached6", st_cyc.size() - sb >= 6, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_core_start", bus.core_start, 0);
      wb = wr_addr.size(); db = done_cnt;
      repeat (30) @(negedge clk);
      chk("rst_mid_stale_we", wr_addr.size() - wb, 0);
      chk("rst_mid_no_done", done_cnt - db, 0);
      do_run(16'h0100, 0, 0, c0, wb, sb, db);
      chk_writes("after_rst", wb, db, 16'h0100);

      // spurious core_done while idle
      wb = wr_addr.size(); db = done_cnt;
      inj_done = 4'b0100; inj_hash[2] = 32'h1234_5678;
      @(negedge clk);
      inj_done = '0; inj_hash = '0;
      repeat (3) @(negedge clk);
      chk("spur_done_we", wr_addr.size() - wb, 0);
      chk("spur_done_busy", bus.busy, 0);
      chk("spur_done_done", done_cnt - db, 0);

      // start during RUN ignored, address wrap
      do_run(16'hFFF8, 0, 10, c0, wb, sb, db);
      chk_writes("wrap", wb, db, 16'hFFF8);

      // single nonce, single core
      @(negedge clk);
      bus1.output_addr = 16'h0200; bus1.start = 1'b1; c1 = cyc;
      @(negedge clk);
      bus1.start = 1'b0;
      n = 0;
      while (d1_cnt == 0 && n < 200) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      chk("one_disp_cnt", st1_cnt, 1);
      chk("one_disp_cyc", st1_cyc, c1 + 1);
      chk("one_disp_nonce", st1_nonce, 0);
      chk("one_wr_cnt", wr1_cnt, 1);
      chk("one_wr_cyc", wr1_cyc, c1 + 22);
      chk("one_wr_addr", wr1_addr, 16'h0200);
      chk("one_wr_data", wr1_data, 32'hA000_0000);
      chk("one_done_cnt", d1_cnt, 1);
      chk("one_done_cyc", d1_cyc, c1 + 23);
      chk("one_busy_rise", b1_rise, c1 + 1);
      chk("one_busy_fall", b1_fall, c1 + 24);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
